bundle_sequencer: RTL and testbench
===================================

Name: bundle_sequencer

Overview:
- Sequences one full-hypervector bundling pass over a PAR_BITS-wide bit-parallel bundler.
- Steps a chunk index across DIM bits and issues one bundler job per chunk over the en/done handshake.
- Writes each returned PAR_BITS slice into the destination HV memory through a masked write port.
- Sits between the encoder top-level FSM (start/done) and the bundler datapath plus the HV memories.

Parameters:
DIM, 1000, hypervector dimension in bits
PAR_BITS, 10, bits processed per bundler job
NUM_CHUNKS, ceil(DIM/PAR_BITS) (localparam), jobs per pass
CW, $clog2(NUM_CHUNKS) (localparam, min 1), chunk index width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin a pass; sampled only in IDLE
abort  input  1  cancel current pass; sampled in any non-IDLE state
busy  output  1  high from the cycle after start is accepted until the return to IDLE
done  output  1  one-cycle pulse at normal pass completion
chunk_idx  output  CW  current chunk; selects the input HV slices and tie vectors
bnd_en  output  1  one-cycle job request to the bundler
bnd_done  input  1  bundler done; high when idle, low while counting
bnd_out_bits  input  PAR_BITS  bundler result, valid while bnd_done is high after a job
wr_en  output  1  destination memory write strobe
wr_addr  output  CW  destination word address (= chunk_idx)
wr_data  output  PAR_BITS  registered bnd_out_bits
wr_mask  output  PAR_BITS  per-bit write enable; all ones except on a partial last chunk

Behaviour:
- Reset: rst=1 at a clock edge gives state=IDLE and busy=0, done=0, bnd_en=0, wr_en=0, chunk_idx=0, wr_addr=0, wr_data=0, wr_mask=0. Reset applies from any state, including mid-pass.
- All outputs are registered.
- States and transitions:
  - IDLE: start=1 → ISSUE, chunk_idx<=0, busy<=1.
  - ISSUE: bnd_en<=1 for exactly one cycle → WAIT_LOW.
  - WAIT_LOW: stay until bnd_done=0, then → WAIT_HIGH. bnd_done being high on entry (stale idle level) is never treated as completion.
  - WAIT_HIGH: stay until bnd_done=1. On that cycle capture wr_data<=bnd_out_bits, wr_addr<=chunk_idx, wr_mask, and wr_en<=1 for one cycle → ADVANCE.
  - ADVANCE:
    - If chunk_idx==NUM_CHUNKS-1: done<=1 (one cycle), busy<=0 → IDLE.
    - Otherwise: chunk_idx<=chunk_idx+1 → ISSUE.
- chunk_idx holds stable from ISSUE through ADVANCE, so the input mux stays valid for the whole bundler count phase. It never exceeds NUM_CHUNKS-1; there is no wrap.
- Partial last chunk: when DIM%PAR_BITS=R≠0, the last chunk's wr_mask has only the low R bits set; all other chunks use all ones. When R=0 every mask is all ones.
- abort=1 in any non-IDLE state: next state IDLE, busy<=0, and no done pulse.
  - A write already registered in the same cycle still completes.
  - No new bnd_en is issued.
  - The bundler is left to finish on its own. The next start is only legal once bnd_done=1, and the sequencer enforces this: start is ignored while bnd_done=0.
- start while busy: ignored.
- start and abort together in IDLE: start wins (abort has no meaning in IDLE).
- Per-chunk latency: 1 (ISSUE) + bundler latency + 1 (ADVANCE).
- Pass latency: NUM_CHUNKS × per-chunk latency, with no idle cycles between chunks beyond ISSUE/ADVANCE.
- With a NUM_HVS=17 bundler (19-cycle job), per-chunk time is 21 cycles.

Test Plan:
- DIM=30, PAR_BITS=10, bundler model with 19-cycle job, start pulse → bnd_en pulses at 3 chunk_idx values 0,1,2.
  - Expect 3 writes to wr_addr 0,1,2, each with wr_mask=0x3FF, and done exactly 63 cycles after the start edge.
- DIM=25, PAR_BITS=10 → 3 chunks; the last write has wr_mask=0x01F, the first two 0x3FF. wr_data equals the model output 0x2A5, 0x15A, 0x0F0.
- bnd_done held high for 3 extra cycles after bnd_en (slow-dropping bundler) → no write until bnd_done falls and then rises again; exactly one write per chunk.
- abort asserted in WAIT_HIGH of chunk 1 → IDLE on the next cycle.
  - Expect busy=0, no done pulse, no write for chunk 1.
  - A start while bnd_done=0 is ignored; a start after bnd_done=1 restarts at chunk 0.
- rst=1 for one cycle in WAIT_LOW of chunk 2 → all outputs 0 on the next cycle. A later start runs a full clean pass.
- start re-pulsed at cycles 5 and 30 of a pass → ignored; still exactly NUM_CHUNKS writes and one done pulse.

Source files
------------

// File: rtl/bundle_sequencer_if.sv
// ============================================================================
// Module   : bundle_sequencer_if
// Brief    : Control, bundler-job and destination-write signals of the
//            bundling sequencer, grouped for master/slave hookup.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bundle_sequencer_if #(
    parameter int DIM      = 1000,
    parameter int PAR_BITS = 10
);
    localparam int c_num_chunks = (DIM + PAR_BITS - 1) / PAR_BITS;
    localparam int c_cw         = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;

    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic [c_cw-1:0]     chunk_idx;
    logic                bnd_en;
    logic                bnd_done;
    logic [PAR_BITS-1:0] bnd_out_bits;
    logic                wr_en;
    logic [c_cw-1:0]     wr_addr;
    logic [PAR_BITS-1:0] wr_data;
    logic [PAR_BITS-1:0] wr_mask;

    modport master (
        input  start, abort, bnd_done, bnd_out_bits,
        output busy, done, chunk_idx, bnd_en, wr_en, wr_addr, wr_data, wr_mask
    );

    modport slave (
        output start, abort, bnd_done, bnd_out_bits,
        input  busy, done, chunk_idx, bnd_en, wr_en, wr_addr, wr_data, wr_mask
    );
endinterface

`default_nettype wire

// File: rtl/bundle_sequencer.sv
// ============================================================================
// Module   : bundle_sequencer
// Brief    : Walks DIM bits in PAR_BITS chunks, issuing one bundler job per
//            chunk and writing each returned slice to the destination HV.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bundle_sequencer #(
    parameter int DIM      = 1000,
    parameter int PAR_BITS = 10
) (
    input  wire logic          clk,
    input  wire logic          rst,
    bundle_sequencer_if.master bus
);
    localparam int c_num_chunks = (DIM + PAR_BITS - 1) / PAR_BITS;
    localparam int c_cw         = (c_num_chunks > 1) ? $clog2(c_num_chunks) : 1;
    localparam int c_rem        = DIM % PAR_BITS;

    localparam logic [c_cw-1:0]     c_last      = c_cw'(c_num_chunks - 1);
    localparam logic [c_cw-1:0]     c_one       = c_cw'(1);
    localparam logic [PAR_BITS-1:0] c_full_mask = {PAR_BITS{1'b1}};
    localparam logic [PAR_BITS-1:0] c_last_mask =
        (c_rem == 0) ? c_full_mask : (c_full_mask >> (PAR_BITS - c_rem));

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_issue     = 3'd1;
    localparam logic [2:0] c_st_wait_low  = 3'd2;
    localparam logic [2:0] c_st_wait_high = 3'd3;
    localparam logic [2:0] c_st_advance   = 3'd4;

    logic [2:0]          r_state, w_state_next;
    logic                r_busy, w_busy;
    logic                r_done, w_done;
    logic                r_bnd_en, w_bnd_en;
    logic                r_wr_en, w_wr_en;
    logic [c_cw-1:0]     r_chunk, w_chunk;
    logic [c_cw-1:0]     r_wr_addr, w_wr_addr;
    logic [PAR_BITS-1:0] r_wr_data, w_wr_data;
    logic [PAR_BITS-1:0] r_wr_mask, w_wr_mask;

    logic w_abort;
    logic w_accept;

    // A new pass may only begin once the bundler is idle again.
    assign w_abort  = (r_state != c_st_idle) && bus.abort;
    assign w_accept = (r_state == c_st_idle) && bus.start && bus.bnd_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:      if (w_accept) w_state_next = c_st_issue;
                c_st_issue:     w_state_next = c_st_wait_low;
                c_st_wait_low:  if (!bus.bnd_done) w_state_next = c_st_wait_high;
                c_st_wait_high: if (bus.bnd_done) w_state_next = c_st_advance;
                c_st_advance:   w_state_next = (r_chunk == c_last) ? c_st_idle : c_st_issue;
                default:        w_state_next = c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_bnd_en  = 1'b0;
        w_wr_en   = 1'b0;
        w_chunk   = r_chunk;
        w_wr_addr = r_wr_addr;
        w_wr_data = r_wr_data;
        w_wr_mask = r_wr_mask;
        if (w_abort) begin
            w_busy = 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        w_busy  = 1'b1;
                        w_chunk = '0;
                    end
                end
                c_st_issue: w_bnd_en = 1'b1;
                c_st_wait_high: begin
                    if (bus.bnd_done) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_chunk;
                        w_wr_data = bus.bnd_out_bits;
                        w_wr_mask = (r_chunk == c_last) ? c_last_mask : c_full_mask;
                    end
                end
                c_st_advance: begin
                    if (r_chunk == c_last) begin
                        w_done = 1'b1;
                        w_busy = 1'b0;
                    end else begin
                        w_chunk = r_chunk + c_one;
                    end
                end
                default: w_busy = r_busy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bnd_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_chunk   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_mask <= '0;
        end else begin
            r_busy    <= w_busy;
            r_done    <= w_done;
            r_bnd_en  <= w_bnd_en;
            r_wr_en   <= w_wr_en;
            r_chunk   <= w_chunk;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_wr_mask <= w_wr_mask;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.bnd_en    = r_bnd_en;
    assign bus.wr_en     = r_wr_en;
    assign bus.chunk_idx = r_chunk;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.wr_mask   = r_wr_mask;

endmodule

`default_nettype wire

// File: tb/tb_bundle_sequencer.sv
// ============================================================================
// Module   : tb_bundle_sequencer
// Brief    : Two sequencers (DIM=30 and DIM=25) driven by one bundler model,
//            compared every cycle against a job-level reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bundle_sequencer;
    localparam int PB    = 10;
    localparam int DIM_A = 30;
    localparam int DIM_B = 25;
    localparam int NCH   = 3;

    logic clk = 1'b0;
    logic rst;
    logic start, abort, bnd_done;
    logic [PB-1:0] bnd_out_bits;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bundle_sequencer_if #(.DIM(DIM_A), .PAR_BITS(PB)) bus_a ();
    bundle_sequencer_if #(.DIM(DIM_B), .PAR_BITS(PB)) bus_b ();

    assign bus_a.start = start;        assign bus_b.start = start;
    assign bus_a.abort = abort;        assign bus_b.abort = abort;
    assign bus_a.bnd_done = bnd_done;  assign bus_b.bnd_done = bnd_done;
    assign bus_a.bnd_out_bits = bnd_out_bits;
    assign bus_b.bnd_out_bits = bnd_out_bits;

    bundle_sequencer #(.DIM(DIM_A), .PAR_BITS(PB)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
    bundle_sequencer #(.DIM(DIM_B), .PAR_BITS(PB)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PB-1:0] mask_for(input int dim, input int chunk);
        int r = dim % PB;
        int n = (dim + PB - 1) / PB;
        if (chunk == n - 1 && r != 0) return PB'((1 << r) - 1);
        return {PB{1'b1}};
    endfunction

    // Bundler: after a job request, bnd_done stays high for 'extra' cycles, then low 18 cycles.
    int       extra = 0;
    bit       bund_active = 1'b0;
    int       bt = 0;
    bit       fixed_vals = 1'b1;
    logic [PB-1:0] tbl [3] = '{10'h2A5, 10'h15A, 10'h0F0};
    logic [PB-1:0] job_val;

    // Reference model: job-level bookkeeping of the pass, expectations for the next edge.
    bit  armed = 1'b0;
    bit  pass_on, issue_due, job_open, saw_low, adv_due;
    logic e_busy, e_done, e_bnd_en, e_wr_en;
    int  e_chunk, e_addr;
    logic [PB-1:0] e_data, e_mask_a, e_mask_b;

    int  done_count = 0;
    int  done_cyc = 0;
    int  wr_addr_log[$];
    logic [PB-1:0] wr_data_log[$], wr_mask_a_log[$], wr_mask_b_log[$];

    task automatic model_step();
        e_done = 1'b0; e_bnd_en = 1'b0; e_wr_en = 1'b0;
        if (rst) begin
            armed = 1'b1;
            pass_on = 0; issue_due = 0; job_open = 0; saw_low = 0; adv_due = 0;
            e_busy = 1'b0; e_chunk = 0; e_addr = 0; e_data = '0; e_mask_a = '0; e_mask_b = '0;
        end else if (!pass_on) begin
            if (start && bnd_done) begin
                pass_on = 1; e_busy = 1'b1; e_chunk = 0; issue_due = 1;
            end
        end else if (abort) begin
            pass_on = 0; issue_due = 0; job_open = 0; adv_due = 0; e_busy = 1'b0;
        end else if (issue_due) begin
            issue_due = 0; e_bnd_en = 1'b1; job_open = 1; saw_low = 0;
        end else if (job_open) begin
            if (!saw_low) begin
                saw_low = !bnd_done;
            end else if (bnd_done) begin
                e_wr_en = 1'b1; e_addr = e_chunk; e_data = bnd_out_bits;
                e_mask_a = mask_for(DIM_A, e_chunk); e_mask_b = mask_for(DIM_B, e_chunk);
                job_open = 0; adv_due = 1;
            end
        end else if (adv_due) begin
            adv_due = 0;
            if (e_chunk == NCH - 1) begin
                e_done = 1'b1; e_busy = 1'b0; pass_on = 0;
            end else begin
                e_chunk = e_chunk + 1; issue_due = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("busy_a", bus_a.busy, e_busy);       check("busy_b", bus_b.busy, e_busy);
            check("done_a", bus_a.done, e_done);       check("done_b", bus_b.done, e_done);
            check("bnd_en_a", bus_a.bnd_en, e_bnd_en); check("bnd_en_b", bus_b.bnd_en, e_bnd_en);
            check("wr_en_a", bus_a.wr_en, e_wr_en);    check("wr_en_b", bus_b.wr_en, e_wr_en);
            check("chunk_a", bus_a.chunk_idx, e_chunk); check("chunk_b", bus_b.chunk_idx, e_chunk);
            check("addr_a", bus_a.wr_addr, e_addr);    check("addr_b", bus_b.wr_addr, e_addr);
            check("data_a", bus_a.wr_data, e_data);    check("data_b", bus_b.wr_data, e_data);
            check("mask_a", bus_a.wr_mask, e_mask_a);  check("mask_b", bus_b.wr_mask, e_mask_b);
        end
        if (bus_a.wr_en === 1'b1) begin
            wr_addr_log.push_back(int'(bus_a.wr_addr));
            wr_data_log.push_back(bus_a.wr_data);
            wr_mask_a_log.push_back(bus_a.wr_mask);
            wr_mask_b_log.push_back(bus_b.wr_mask);
        end
        if (bus_a.done === 1'b1) begin
            done_count++;
            done_cyc = cyc;
        end
        if (bus_a.bnd_en === 1'b1) begin
            bund_active = 1'b1;
            bt = 0;
            job_val = fixed_vals ? tbl[int'(bus_a.chunk_idx) % 3] : PB'($urandom);
        end else if (bund_active) begin
            bt++;
        end
        if (bund_active) begin
            if (bt >= extra + 18) begin
                bnd_done = 1'b1; bnd_out_bits = job_val; bund_active = 1'b0;
            end else if (bt >= extra) begin
                bnd_done = 1'b0; bnd_out_bits = PB'($urandom);
            end
        end
        model_step();
    end

    int st_edge = 0;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; st_edge = cyc + 1; step(); start = 1'b0;
    endtask

    task automatic clear_logs();
        wr_addr_log.delete(); wr_data_log.delete();
        wr_mask_a_log.delete(); wr_mask_b_log.delete();
        done_count = 0;
    endtask

    task automatic timeout(input string what);
        n_cmp++; n_bad++;
        $display("FAIL timeout_%s: got no event, expected one within bound (cycle %0d)", what, cyc);
    endtask

    task automatic wait_done(input int maxc);
        int k = 0;
        while (bus_a.done !== 1'b1 && k < maxc) begin step(); k++; end
        if (k >= maxc) timeout("done");
        step();
    endtask

    task automatic wait_issue(input int ch, input int maxc);
        int k = 0;
        while (!(bus_a.bnd_en === 1'b1 && int'(bus_a.chunk_idx) == ch) && k < maxc) begin step(); k++; end
        if (k >= maxc) timeout("issue");
    endtask

    task automatic wait_bundler_idle(input int maxc);
        int k = 0;
        while ((bund_active || bnd_done !== 1'b1) && k < maxc) begin step(); k++; end
        if (k >= maxc) timeout("bundler_idle");
    endtask

    int abort_at;

    initial begin
        start = 1'b0; abort = 1'b0; bnd_done = 1'b1; bnd_out_bits = '0; rst = 1'b1;
        repeat (3) step();
        check("rst_busy", bus_a.busy, 0);
        check("rst_chunk", bus_b.chunk_idx, 0);
        check("rst_mask", bus_b.wr_mask, 0);
        rst = 1'b0;
        step();

        // Basic pass, fixed bundler results, 19-cycle jobs
        clear_logs(); pulse_start(); wait_done(200);
        check("latency", done_cyc - st_edge, 63);
        check("p1_writes", wr_addr_log.size(), 3);
        if (wr_addr_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("p1_addr", wr_addr_log[i], i);
                check("p1_mask30", wr_mask_a_log[i], 10'h3FF);
                check("p1_data", wr_data_log[i], tbl[i]);
            end
            check("p1_mask25_0", wr_mask_b_log[0], 10'h3FF);
            check("p1_mask25_1", wr_mask_b_log[1], 10'h3FF);
            check("p1_mask25_2", wr_mask_b_log[2], 10'h01F);
        end
        check("p1_done_cnt", done_count, 1);
        fixed_vals = 1'b0;

        // Slow-dropping bundler
        extra = 3; clear_logs(); pulse_start(); wait_done(300);
        check("slow_writes", wr_addr_log.size(), 3);
        check("slow_done_cnt", done_count, 1);

        // Abort during chunk 1, then start gated by bnd_done
        extra = 0; clear_logs(); pulse_start();
        wait_issue(1, 100);
        repeat (5) step();
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_busy", bus_a.busy, 0);
        step();
        start = 1'b1; step(); start = 1'b0; step();
        check("gated_start_busy", bus_a.busy, 0);
        check("abort_writes", wr_addr_log.size(), 1);
        check("abort_done_cnt", done_count, 0);
        wait_bundler_idle(100);
        clear_logs(); pulse_start();
        check("restart_busy", bus_a.busy, 1);
        check("restart_chunk", bus_a.chunk_idx, 0);
        wait_done(200);
        check("restart_writes", wr_addr_log.size(), 3);

        // Reset in WAIT_LOW of chunk 2
        extra = 2; clear_logs(); pulse_start();
        wait_issue(2, 200);
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_rst_busy", bus_a.busy, 0);
        check("mid_rst_wr_en", bus_a.wr_en, 0);
        check("mid_rst_chunk", bus_a.chunk_idx, 0);
        check("mid_rst_data", bus_a.wr_data, 0);
        check("mid_rst_mask", bus_a.wr_mask, 0);
        wait_bundler_idle(100);
        clear_logs(); pulse_start(); wait_done(300);
        check("post_rst_writes", wr_addr_log.size(), 3);

        // Start+abort together in IDLE, then stray starts mid-pass
        extra = 0; clear_logs();
        start = 1'b1; abort = 1'b1; st_edge = cyc + 1; step(); start = 1'b0; abort = 1'b0;
        check("start_wins_busy", bus_a.busy, 1);
        repeat (3) step(); start = 1'b1; step(); start = 1'b0;
        repeat (24) step(); start = 1'b1; step(); start = 1'b0;
        wait_done(200);
        check("repulse_latency", done_cyc - st_edge, 63);
        check("repulse_writes", wr_addr_log.size(), 3);
        check("repulse_done_cnt", done_count, 1);

        // Randomized passes with random aborts, stray starts and bundler timing
        for (int p = 0; p < 10; p++) begin
            extra = $urandom_range(0, 4);
            wait_bundler_idle(100);
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 70)) : -1;
            pulse_start();
            for (int k = 0; k < 300; k++) begin
                if (bus_a.done === 1'b1 || bus_a.busy !== 1'b1) break;
                if (k == abort_at) abort = 1'b1;
                else if ($urandom_range(0, 15) == 0) start = 1'b1;
                step();
                abort = 1'b0; start = 1'b0;
            end
            repeat (2) step();
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
